shuffle_s_mem_by_key: RTL and testbench

RC4 key-scheduling stage that runs directly after the S-memory identity fill (s[i]=i).
It performs the 256-iteration KSA swap loop on the 256x8 S memory:
- j = j + s[i] + key[i mod KEY_LENGTH]
- swap s[i], s[j]

It drives the memory's single read/write port through the top-level S-memory mux and signals completion to the PRGA/decrypt stage downstream.

---
 rtl/shuffle_s_mem_by_key.sv | 193 +++++++++++++++++++
 tb/tb_shuffle_s_mem_by_key.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shuffle_s_mem_by_key.sv
// ---------------------------------------------------------------------------
// shuffle_s_mem_by_key
//
// RC4 key-scheduling (KSA) stage. It runs after the S memory has been filled
// with the identity permutation s[i] = i. For i = 0..255 it computes
// j = j + s[i] + key[i mod KEY_LENGTH] (mod 256) and swaps s[i] and s[j].
// It drives the single read/write port of the 256x8 S memory and reports
// completion to the downstream PRGA/decrypt stage.
//
// Memory timing: reads are synchronous, with q valid two edges after the
// address changes. Every read therefore takes an issue state and a wait
// state. A write commits on the edge that ends the cycle in which
// write_enable_out is high.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   start            begin KSA; sampled only while idle or done
//   secret_key       key bytes, byte 0 in the top 8 bits; latched on start
//   mem_q_in         S-memory read data
//   address_out      S-memory address (registered)
//   data_out         S-memory write data (registered)
//   write_enable_out S-memory write enable (registered)
//   busy             high while the swap loop is running
//   done             level, high once the loop has finished
// ---------------------------------------------------------------------------
module shuffle_s_mem_by_key #(
  parameter int KEY_LENGTH = 3,
  parameter int KEY_WIDTH  = 8 * KEY_LENGTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] secret_key,
  input  logic [7:0]           mem_q_in,
  output logic [7:0]           address_out,
  output logic [7:0]           data_out,
  output logic                 write_enable_out,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [3:0] {
    IDLE,
    READ_SI,
    WAIT_SI,
    CALC_J,
    READ_SJ,
    WAIT_SJ,
    LATCH_SJ,
    WRITE_SI,
    WRITE_SJ,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [8:0]           i_q, i_d;
  logic [7:0]           j_q, j_d;
  logic [7:0]           sI_q, sI_d;
  logic [7:0]           sJ_q, sJ_d;
  logic [KEY_WIDTH-1:0] keyReg_q, keyReg_d;
  logic [IDX_W-1:0]     keyIdx_q, keyIdx_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic                 we_q, we_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [KEY_WIDTH-1:0] keyShift;
  logic [7:0]           keyByte;

  // Key bytes are stored MSB-first, so shifting left by 8*keyIdx brings the
  // selected byte into the top 8 bits without any divider or wide mux.
  always_comb begin
    keyShift = keyReg_q << {keyIdx_q, 3'b000};
    keyByte  = keyShift[KEY_WIDTH-1 -: 8];
  end

  // Next-state logic. The memory-facing outputs are registered, so each
  // transition loads the address/data/enable that the destination state
  // presents to the memory during its own cycle.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    sI_d     = sI_q;
    sJ_d     = sJ_q;
    keyReg_d = keyReg_q;
    keyIdx_d = keyIdx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          keyReg_d = secret_key;
          i_d      = 9'd0;
          j_d      = 8'd0;
          keyIdx_d = '0;
          addr_d   = 8'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          state_d  = READ_SI;
        end
      end
      READ_SI: state_d = WAIT_SI;
      WAIT_SI: state_d = CALC_J;
      CALC_J: begin
        sI_d    = mem_q_in;
        j_d     = j_q + mem_q_in + keyByte;
        addr_d  = j_d;
        state_d = READ_SJ;
      end
      READ_SJ: state_d = WAIT_SJ;
      WAIT_SJ: state_d = LATCH_SJ;
      LATCH_SJ: begin
        sJ_d    = mem_q_in;
        addr_d  = i_q[7:0];
        data_d  = mem_q_in;
        we_d    = 1'b1;
        state_d = WRITE_SI;
      end
      WRITE_SI: begin
        addr_d  = j_q;
        data_d  = sI_q;
        we_d    = 1'b1;
        state_d = WRITE_SJ;
      end
      WRITE_SJ: begin
        // When i == j both writes hit the same address with the same value,
        // so no special case is needed and the cycle count stays fixed.
        i_d = i_q + 9'd1;
        if (keyIdx_q == IDX_W'(KEY_LENGTH - 1)) begin
          keyIdx_d = '0;
        end else begin
          keyIdx_d = keyIdx_q + IDX_W'(1);
        end
        if (i_q == 9'd255) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = i_d[7:0];
          state_d = READ_SI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any swap in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      i_q      <= 9'd0;
      j_q      <= 8'd0;
      sI_q     <= 8'd0;
      sJ_q     <= 8'd0;
      keyReg_q <= '0;
      keyIdx_q <= '0;
      addr_q   <= 8'd0;
      data_q   <= 8'd0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      sI_q     <= sI_d;
      sJ_q     <= sJ_d;
      keyReg_q <= keyReg_d;
      keyIdx_q <= keyIdx_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign address_out      = addr_q;
  assign data_out         = data_q;
  assign write_enable_out = we_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_shuffle_s_mem_by_key.sv
// ---------------------------------------------------------------------------
// tb_shuffle_s_mem_by_key
//
// Directed bench for the RC4 key-scheduling stage. Two instances are used:
// one with the default 3-byte key and one with a 4-byte key. Each drives its
// own behavioural 256x8 memory whose read data appears two edges after the
// address changes. Expected S images come from a software KSA model.
// ---------------------------------------------------------------------------
module tb_shuffle_s_mem_by_key;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] secretKey;
  logic [7:0]  memQ;
  logic [7:0]  addrOut;
  logic [7:0]  dataOut;
  logic        weOut;
  logic        busyOut;
  logic        doneOut;

  logic        start4;
  logic [31:0] key4;
  logic [7:0]  memQ4;
  logic [7:0]  addr4;
  logic [7:0]  data4;
  logic        we4;
  logic        busy4;
  logic        done4;

  logic [7:0]  mem [256];
  logic [7:0]  mem4 [256];
  logic [7:0]  addrReg;
  logic [7:0]  addrReg4;
  logic [7:0]  sModel [256];
  logic [7:0]  snap [256];
  logic [7:0]  wrA [8];
  logic [7:0]  wrD [8];
  int          wrN;
  bit          fillReq;

  int vecCount;
  int missCount;
  int doneAt;
  int busyCnt;
  int weCnt;

  shuffle_s_mem_by_key #(.KEY_LENGTH(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .secret_key       (secretKey),
    .mem_q_in         (memQ),
    .address_out      (addrOut),
    .data_out         (dataOut),
    .write_enable_out (weOut),
    .busy             (busyOut),
    .done             (doneOut)
  );

  shuffle_s_mem_by_key #(.KEY_LENGTH(4)) dut4 (
    .clk              (clk),
    .reset            (reset),
    .start            (start4),
    .secret_key       (key4),
    .mem_q_in         (memQ4),
    .address_out      (addr4),
    .data_out         (data4),
    .write_enable_out (we4),
    .busy             (busy4),
    .done             (done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural S memories: address registered, then data registered, so
  // q follows the address by two edges. A fill request reloads identity.
  always @(posedge clk) begin
    if (fillReq) begin
      for (int a = 0; a < 256; a++) begin
        mem[a]  <= 8'(a);
        mem4[a] <= 8'(a);
      end
    end else begin
      if (weOut) mem[addrOut] <= dataOut;
      if (we4) mem4[addr4] <= data4;
    end
    addrReg  <= addrOut;
    memQ     <= mem[addrReg];
    addrReg4 <= addr4;
    memQ4    <= mem4[addrReg4];
  end

  // Log of the first few writes of the main instance since the last fill.
  always @(posedge clk) begin
    if (fillReq) begin
      wrN <= 0;
    end else if (weOut && wrN < 8) begin
      wrA[wrN] <= addrOut;
      wrD[wrN] <= dataOut;
      wrN      <= wrN + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic fillIdentity();
    @(negedge clk);
    fillReq = 1'b1;
    @(negedge clk);
    fillReq = 1'b0;
    for (int a = 0; a < 256; a++) sModel[a] = 8'(a);
  endtask

  task automatic ksaModel(input logic [31:0] key, input int keyLen);
    logic [7:0]  jj;
    logic [7:0]  t;
    logic [31:0] sh;
    jj = 8'd0;
    for (int ii = 0; ii < 256; ii++) begin
      sh = key >> (8 * (keyLen - 1 - (ii % keyLen)));
      jj = jj + sModel[ii] + sh[7:0];
      t = sModel[ii];
      sModel[ii] = sModel[jj];
      sModel[jj] = t;
    end
  endtask

  task automatic compareAll(input string tag, input bit use4);
    for (int a = 0; a < 256; a++) begin
      checkOutput($sformatf("%s[%0d]", tag, a),
                  32'(use4 ? mem4[a] : mem[a]), 32'(sModel[a]));
    end
  endtask

  // Pulses start on the main instance and follows the run edge by edge.
  // k counts edges after the accepting edge. Optional hooks snapshot the
  // memory, re-pulse start with a different key, or assert reset.
  task automatic applyStimulus(input logic [23:0] key, input int snapAt,
                               input int resetAt, input int repulseAt,
                               input logic [23:0] altKey);
    int k;
    bit stop;
    @(negedge clk);
    secretKey = key;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    doneAt = -1;
    busyCnt = 0;
    weCnt = 0;
    stop = 1'b0;
    while (!stop && k <= 2200) begin
      if (busyOut) busyCnt++;
      if (weOut) weCnt++;
      if (doneOut) begin
        doneAt = k;
        stop = 1'b1;
      end else begin
        if (k == snapAt) for (int a = 0; a < 256; a++) snap[a] = mem[a];
        if (k == resetAt) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          checkOutput("rstWe", 32'(weOut), 32'd0);
          checkOutput("rstBusy", 32'(busyOut), 32'd0);
          checkOutput("rstDone", 32'(doneOut), 32'd0);
          checkOutput("rstAddr", 32'(addrOut), 32'd0);
          stop = 1'b1;
        end else begin
          start = (k == repulseAt);
          if (k == repulseAt) secretKey = altKey;
          @(negedge clk);
          k++;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic checkTiming(input string tag);
    checkOutput({tag, "DoneAt"}, 32'(doneAt), 32'd2048);
    checkOutput({tag, "Busy"}, 32'(busyCnt), 32'd2048);
    checkOutput({tag, "We"}, 32'(weCnt), 32'd512);
  endtask

  initial begin
    int k;
    vecCount = 0;
    missCount = 0;
    fillReq = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    secretKey = 24'd0;
    start4 = 1'b0;
    key4 = 32'd0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    checkOutput("resetAddr", 32'(addrOut), 32'd0);
    checkOutput("resetData", 32'(dataOut), 32'd0);
    checkOutput("resetWe", 32'(weOut), 32'd0);
    checkOutput("resetBusy", 32'(busyOut), 32'd0);
    checkOutput("resetDone", 32'(doneOut), 32'd0);
    checkOutput("resetBusy4", 32'(busy4), 32'd0);
    checkOutput("resetDone4", 32'(done4), 32'd0);
    reset = 1'b0;

    // All-zero key: check the first write pairs and the early swaps.
    $display("[TB] key 000000");
    fillIdentity();
    applyStimulus(24'h000000, 24, -1, -1, 24'h0);
    checkOutput("t1WrN", 32'(wrN), 32'd8);
    checkOutput("t1A0", 32'(wrA[0]), 32'd0);
    checkOutput("t1D0", 32'(wrD[0]), 32'd0);
    checkOutput("t1A1", 32'(wrA[1]), 32'd0);
    checkOutput("t1D1", 32'(wrD[1]), 32'd0);
    checkOutput("t1A2", 32'(wrA[2]), 32'd1);
    checkOutput("t1D2", 32'(wrD[2]), 32'd1);
    checkOutput("t1A3", 32'(wrA[3]), 32'd1);
    checkOutput("t1D3", 32'(wrD[3]), 32'd1);
    checkOutput("t1A4", 32'(wrA[4]), 32'd2);
    checkOutput("t1D4", 32'(wrD[4]), 32'd3);
    checkOutput("t1A5", 32'(wrA[5]), 32'd3);
    checkOutput("t1D5", 32'(wrD[5]), 32'd2);
    checkOutput("t1S0", 32'(snap[0]), 32'd0);
    checkOutput("t1S1", 32'(snap[1]), 32'd1);
    checkOutput("t1S2", 32'(snap[2]), 32'd3);
    checkOutput("t1S3", 32'(snap[3]), 32'd2);
    checkTiming("t1");
    ksaModel(32'h000000, 3);
    compareAll("t1S", 1'b0);

    // Key 010203: first two swaps by hand, then the whole image.
    $display("[TB] key 010203");
    fillIdentity();
    applyStimulus(24'h010203, 16, -1, -1, 24'h0);
    checkOutput("t2S0", 32'(snap[0]), 32'd1);
    checkOutput("t2S1", 32'(snap[1]), 32'd3);
    checkOutput("t2S3", 32'(snap[3]), 32'd0);
    checkTiming("t2");
    ksaModel(32'h010203, 3);
    compareAll("t2S", 1'b0);

    // Reset in the middle of the loop, then a clean rerun.
    $display("[TB] reset mid-loop");
    fillIdentity();
    applyStimulus(24'h010203, -1, 1000, -1, 24'h0);
    fillIdentity();
    applyStimulus(24'h010203, -1, -1, -1, 24'h0);
    checkTiming("t4");
    ksaModel(32'h010203, 3);
    compareAll("t4S", 1'b0);

    // start re-pulsed and key changed while busy; then restart from done.
    $display("[TB] start while busy");
    fillIdentity();
    applyStimulus(24'h5a3c91, -1, -1, 100, 24'hffffff);
    checkTiming("t5a");
    ksaModel(32'h5a3c91, 3);
    compareAll("t5aS", 1'b0);
    applyStimulus(24'h0badf0, -1, -1, -1, 24'h0);
    checkTiming("t5b");
    ksaModel(32'h0badf0, 3);
    compareAll("t5bS", 1'b0);

    // Four-byte key: key index wraps back to byte 0 at i = 4.
    $display("[TB] four-byte key");
    fillIdentity();
    @(negedge clk);
    key4 = 32'h01020304;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    doneAt = -1;
    while (doneAt < 0 && k <= 2200) begin
      if (done4) begin
        doneAt = k;
      end else begin
        if (k == 40) for (int a = 0; a < 256; a++) snap[a] = mem4[a];
        @(negedge clk);
        k++;
      end
    end
    checkOutput("t6DoneAt", 32'(doneAt), 32'd2048);
    checkOutput("t6S4", 32'(snap[4]), 32'd17);
    checkOutput("t6S17", 32'(snap[17]), 32'd4);
    ksaModel(32'h01020304, 4);
    compareAll("t6S", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
